meter_sched: RTL and testbench

METER_SCHED -- requirements
Module: meter_sched

---
 rtl/meter_pkg.sv | 51 +++++
 rtl/meter_req.sv | 48 ++++
 rtl/meter_sched.sv | 159 +++++++++++++++
 tb/tb_meter_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared op codes, source indices and credit limits for the meter scheduler.
// METER_SCHED_MULTIPRESS_EN selects counted (saturating 2-bit) button requests.
package meter_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ADD10   = 3'd1,
    OP_ADD180  = 3'd2,
    OP_ADD200  = 3'd3,
    OP_ADD550  = 3'd4,
    OP_LOAD10  = 3'd5,
    OP_LOAD205 = 3'd6,
    OP_DEC     = 3'd7
  } op_e;

  // Source index doubles as priority: lower index wins.
  localparam int unsigned NUM_SRC     = 7;
  localparam int unsigned SRC_W       = $clog2(NUM_SRC);
  localparam int unsigned SRC_LOAD10  = 0;
  localparam int unsigned SRC_LOAD205 = 1;
  localparam int unsigned SRC_DEC     = 2;
  localparam int unsigned SRC_ADD10   = 3;
  localparam int unsigned SRC_ADD180  = 4;
  localparam int unsigned SRC_ADD200  = 5;
  localparam int unsigned SRC_ADD550  = 6;

  localparam int unsigned CREDIT_W    = 14;
  localparam int unsigned MAX_CREDIT  = 9999;
  localparam int unsigned FLASH_LIMIT = 200;
  localparam int unsigned PEND_W      = 2;

`ifdef METER_SCHED_MULTIPRESS_EN
  localparam bit BTN_MULTI = 1'b1;
`else
  localparam bit BTN_MULTI = 1'b0;
`endif

  function automatic op_e src_to_op(input logic [SRC_W-1:0] src);
    case (src)
      SRC_W'(SRC_LOAD10):  return OP_LOAD10;
      SRC_W'(SRC_LOAD205): return OP_LOAD205;
      SRC_W'(SRC_DEC):     return OP_DEC;
      SRC_W'(SRC_ADD10):   return OP_ADD10;
      SRC_W'(SRC_ADD180):  return OP_ADD180;
      SRC_W'(SRC_ADD200):  return OP_ADD200;
      SRC_W'(SRC_ADD550):  return OP_ADD550;
      default:             return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/meter_req.sv
// Rising-edge detector plus pending request flag (or saturating count when MULTI).
module meter_req
  import meter_pkg::*;
#(
  parameter bit MULTI = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  input  logic i_grant,
  output logic o_pending_c
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              r_prev;
  logic [PEND_W-1:0] r_cnt;
  logic              w_rise;
  logic [PEND_W-1:0] w_base;
  logic [PEND_W-1:0] w_cnt_nxt;

  assign w_rise = i_level & ~r_prev;

  // Grant consumes first; single-flag mode drops a rise while already pending.
  always_comb begin
    w_base = r_cnt;
    if (i_grant && (r_cnt != '0)) w_base = r_cnt - PEND_W'(1);
    w_cnt_nxt = w_base;
    if (MULTI) begin
      if (w_rise && (w_base != PEND_MAX)) w_cnt_nxt = w_base + PEND_W'(1);
    end else begin
      if (w_rise && (r_cnt == '0)) w_cnt_nxt = PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= i_level;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_level;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_pending_c = (r_cnt != '0);

endmodule

// File: rtl/meter_sched.sv
// Parking-meter operation scheduler: tick generation, request arbitration and display blanking.
// Build option METER_SCHED_MULTIPRESS_EN enables counted button presses.
module meter_sched
  import meter_pkg::*;
#(
  parameter int unsigned DIV = 100000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_u,
  input  logic                btn_l,
  input  logic                btn_r,
  input  logic                btn_d,
  input  logic                sw_rst10,
  input  logic                sw_rst205,
  input  logic [CREDIT_W-1:0] credit,
  output logic                op_valid,
  output logic [2:0]          op_code,
  input  logic                op_ready,
  output logic                tick,
  output logic                blank,
  output logic                tick_miss
);

  localparam int unsigned CNT_W = $clog2(DIV);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  state_e             r_state, w_state_nxt;
  logic               r_op_valid, w_op_valid_nxt;
  op_e                r_op_code, w_op_code_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tick;
  logic               r_blank;
  logic               r_tick_miss;
  logic               r_dec_pend;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_grant;
  logic [SRC_W-1:0]   w_sel;
  logic               w_any;
  logic               w_discard;

  // Free-running second counter; tick is high while the count sits at DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_W'(DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_W'(DIV - 2));
    end
  end

  // DEC request from the tick; a tick that finds DEC still waiting is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_pend  <= 1'b0;
      r_tick_miss <= 1'b0;
    end else if (r_tick) begin
      r_dec_pend <= 1'b1;
      if (r_dec_pend && !w_grant[SRC_DEC]) r_tick_miss <= 1'b1;
    end else if (w_grant[SRC_DEC]) begin
      r_dec_pend <= 1'b0;
    end
  end

  // Low-credit flashing: slow blink below the limit, fast blink at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= 1'b0;
    end else if (credit >= CREDIT_W'(FLASH_LIMIT)) begin
      r_blank <= 1'b0;
    end else if (credit == '0) begin
      if (r_tick || (r_cnt == CNT_W'(DIV / 2 - 1))) r_blank <= ~r_blank;
    end else if (r_tick) begin
      r_blank <= ~r_blank;
    end
  end

  meter_req #(.MULTI(1'b0)) u_req_load10 (
    .clk(clk), .reset(reset), .i_level(sw_rst10),
    .i_grant(w_grant[SRC_LOAD10]), .o_pending_c(w_pend[SRC_LOAD10]));
  meter_req #(.MULTI(1'b0)) u_req_load205 (
    .clk(clk), .reset(reset), .i_level(sw_rst205),
    .i_grant(w_grant[SRC_LOAD205]), .o_pending_c(w_pend[SRC_LOAD205]));
  meter_req #(.MULTI(BTN_MULTI)) u_req_add10 (
    .clk(clk), .reset(reset), .i_level(btn_u),
    .i_grant(w_grant[SRC_ADD10]), .o_pending_c(w_pend[SRC_ADD10]));
  meter_req #(.MULTI(BTN_MULTI)) u_req_add180 (
    .clk(clk), .reset(reset), .i_level(btn_l),
    .i_grant(w_grant[SRC_ADD180]), .o_pending_c(w_pend[SRC_ADD180]));
  meter_req #(.MULTI(BTN_MULTI)) u_req_add200 (
    .clk(clk), .reset(reset), .i_level(btn_r),
    .i_grant(w_grant[SRC_ADD200]), .o_pending_c(w_pend[SRC_ADD200]));
  meter_req #(.MULTI(BTN_MULTI)) u_req_add550 (
    .clk(clk), .reset(reset), .i_level(btn_d),
    .i_grant(w_grant[SRC_ADD550]), .o_pending_c(w_pend[SRC_ADD550]));

  assign w_pend[SRC_DEC] = r_dec_pend;

  // Fixed priority select and discard of pointless requests.
  always_comb begin
    w_any = |w_pend;
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_pend[i]) w_sel = SRC_W'(i);
    end
    w_discard = ((w_sel == SRC_W'(SRC_DEC)) && (credit == '0)) ||
                ((w_sel >= SRC_W'(SRC_ADD10)) && (credit == CREDIT_W'(MAX_CREDIT)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op_valid <= 1'b0;
      r_op_code  <= OP_NOP;
    end else begin
      r_state    <= w_state_nxt;
      r_op_valid <= w_op_valid_nxt;
      r_op_code  <= w_op_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_valid_nxt = r_op_valid;
    w_op_code_nxt  = r_op_code;
    w_grant        = '0;
    case (r_state)
      ST_IDLE: begin
        w_op_valid_nxt = 1'b0;
        w_op_code_nxt  = OP_NOP;
        if (w_any) begin
          w_grant = NUM_SRC'(1) << w_sel;
          if (!w_discard) begin
            w_op_valid_nxt = 1'b1;
            w_op_code_nxt  = src_to_op(w_sel);
            w_state_nxt    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (op_ready) begin
          w_op_valid_nxt = 1'b0;
          w_op_code_nxt  = OP_NOP;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign op_valid  = r_op_valid;
  assign op_code   = r_op_code;
  assign tick      = r_tick;
  assign blank     = r_blank;
  assign tick_miss = r_tick_miss;

endmodule

// File: tb/tb_meter_sched.sv
// Directed bench for meter_sched at DIV=10: cycle table plus multi-cycle corner sequences.
module tb_meter_sched;

  localparam int unsigned DIV = 10;
  localparam int NV = 52;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_u, btn_l, btn_r, btn_d, sw_rst10, sw_rst205;
  logic [13:0] credit;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        op_ready;
  logic        tick, blank, tick_miss;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [13:0] credit;
    logic        ready;
    logic        exp_valid;
    logic [2:0]  exp_code;
    logic        exp_tick;
    logic        exp_blank;
    logic        exp_miss;
  } vec_t;

  vec_t vecs [1:NV];

  always #5 clk = ~clk;

  meter_sched #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .btn_u(btn_u), .btn_l(btn_l), .btn_r(btn_r), .btn_d(btn_d),
    .sw_rst10(sw_rst10), .sw_rst205(sw_rst205),
    .credit(credit),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .tick(tick), .blank(blank), .tick_miss(tick_miss)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut(input logic [13:0] c, input logic rdy);
    btn_u = 0; btn_l = 0; btn_r = 0; btn_d = 0; sw_rst10 = 0; sw_rst205 = 0;
    credit = c; op_ready = rdy; reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_op(input string name, input logic v, input logic [2:0] c);
    check(name, 32'({op_valid, op_code}), 32'({v, c}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n10;
    int n180;
    int exp180;

    // Hand-derived cycle table: row i holds inputs before edge i, outputs after it.
    for (int i = 1; i <= NV; i++) begin
      vecs[i].credit    = (i <= 21) ? 14'd0 : ((i <= 42) ? 14'd300 : 14'd100);
      vecs[i].ready     = 1'b1;
      vecs[i].exp_valid = 1'b0;
      vecs[i].exp_code  = 3'd0;
      vecs[i].exp_tick  = 1'b0;
      vecs[i].exp_blank = 1'b0;
      vecs[i].exp_miss  = 1'b0;
    end
    vecs[9].exp_tick = 1; vecs[19].exp_tick = 1; vecs[29].exp_tick = 1;
    vecs[39].exp_tick = 1; vecs[49].exp_tick = 1;
    for (int i = 5; i <= 9; i++)   vecs[i].exp_blank = 1;
    for (int i = 15; i <= 19; i++) vecs[i].exp_blank = 1;
    for (int i = 50; i <= 52; i++) vecs[i].exp_blank = 1;
    vecs[31].exp_valid = 1; vecs[31].exp_code = 3'd7;
    vecs[41].exp_valid = 1; vecs[41].exp_code = 3'd7;
    vecs[51].exp_valid = 1; vecs[51].exp_code = 3'd7;

    // Reset state
    reset_dut(14'd0, 1'b1);
    check("reset_outputs", 32'({op_valid, op_code, tick, blank, tick_miss}), 32'd0);

    for (int i = 1; i <= NV; i++) begin
      credit   = vecs[i].credit;
      op_ready = vecs[i].ready;
      step();
      check($sformatf("vec[%0d]", i),
            32'({op_valid, op_code, tick, blank, tick_miss}),
            32'({vecs[i].exp_valid, vecs[i].exp_code, vecs[i].exp_tick,
                 vecs[i].exp_blank, vecs[i].exp_miss}));
    end

    // Simultaneous ADD10/ADD550 presses: priority order with an idle gap.
    reset_dut(14'd0, 1'b1);
    btn_u = 1; btn_d = 1;
    step(); check_op("dual_e1", 1'b0, 3'd0);
    step(); check_op("dual_e2_add10", 1'b1, 3'd1);
    step(); check_op("dual_e3_gap", 1'b0, 3'd0);
    step(); check_op("dual_e4_add550", 1'b1, 3'd4);
    step(); check_op("dual_e5", 1'b0, 3'd0);

    // Stalled DEC held stable; third tick finds DEC still pending.
    reset_dut(14'd300, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      step();
      check_op($sformatf("stall_pre_e%0d", e), 1'b0, 3'd0);
    end
    for (int e = 11; e <= 40; e++) begin
      step();
      check($sformatf("stall_hold_e%0d", e), 32'({op_valid, op_code, tick_miss}),
            32'({1'b1, 3'd7, (e >= 30) ? 1'b1 : 1'b0}));
    end
    // Reset while offering abandons the operation.
    reset = 1'b1;
    step();
    check("reset_in_issue", 32'({op_valid, op_code, tick_miss}), 32'd0);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check_op($sformatf("post_reset_e%0d", e), 1'b0, 3'd0);
    end

    // Full credit drops ADD200; LOAD10 waits behind an offered ADD10.
    reset_dut(14'd9999, 1'b0);
    btn_r = 1;
    step(); check_op("full_e1", 1'b0, 3'd0);
    btn_r = 0;
    step(); check_op("full_e2_discard", 1'b0, 3'd0);
    credit = 14'd5000;
    step(); check_op("full_e3_cleared", 1'b0, 3'd0);
    step(); check_op("full_e4_cleared", 1'b0, 3'd0);
    btn_u = 1;
    step(); check_op("add10_e5", 1'b0, 3'd0);
    step(); check_op("add10_e6", 1'b1, 3'd1);
    sw_rst10 = 1;
    for (int e = 7; e <= 10; e++) begin
      step();
      check_op($sformatf("add10_held_e%0d", e), 1'b1, 3'd1);
    end
    op_ready = 1;
    step(); check_op("xfer_e11", 1'b0, 3'd0);
    step(); check_op("load10_e12", 1'b1, 3'd5);
    step(); check_op("xfer_e13", 1'b0, 3'd0);
    step(); check_op("dec_e14", 1'b1, 3'd7);
    step(); check_op("xfer_e15", 1'b0, 3'd0);

    // Four ADD180 rises while another op is stalled.
    reset_dut(14'd0, 1'b0);
    btn_u = 1;
    step();
    step(); check_op("mp_add10_held", 1'b1, 3'd1);
    for (int r = 0; r < 4; r++) begin
      btn_l = 1; step();
      btn_l = 0; step();
    end
    op_ready = 1;
    n10 = 0;
    n180 = 0;
    for (int c = 0; c < 30; c++) begin
      if (op_valid && op_ready) begin
        if (op_code == 3'd1) n10++;
        if (op_code == 3'd2) n180++;
      end
      step();
    end
`ifdef METER_SCHED_MULTIPRESS_EN
    exp180 = 3;
`else
    exp180 = 1;
`endif
    check("mp_add10_count", 32'(n10), 32'd1);
    check("mp_add180_count", 32'(n180), 32'(exp180));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
